// File: rtl/int_to_fp_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : int_to_fp_encoder_if
//  Brief    : Valid/ready bundle between an integer source, the encoder and
//             the minifloat consumer.
//  Revision : 1.0
// ============================================================================
interface int_to_fp_encoder_if #(
    parameter int EXPONENT = 3,
    parameter int MANTISSA = 2,
    parameter int IN_WIDTH = 8
);
    logic                         in_valid;
    logic                         in_ready;
    logic [IN_WIDTH-1:0]          in_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [EXPONENT+MANTISSA:0]   out_fp;
    logic                         out_inf;

    // master: integer producer / result consumer; slave: the encoder itself
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_fp, out_inf
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_fp, out_inf
    );
endinterface
`default_nettype wire

// File: rtl/int_to_fp_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : int_to_fp_encoder
//  Brief    : Signed integer to {S,E,M} minifloat, one normalising shift per
//             cycle. Define FP_ENC_ROUND_EN for round-to-nearest-even,
//             otherwise low bits are truncated.
//  Revision : 1.0
// ============================================================================
module int_to_fp_encoder #(
    parameter int EXPONENT = 3,
    parameter int MANTISSA = 2,
    parameter int IN_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    int_to_fp_encoder_if.slave  bus
);
    localparam int c_FP_W  = 1 + EXPONENT + MANTISSA;
    localparam int c_CNT_W = $clog2(IN_WIDTH + 1);
    localparam int c_EXP_W = EXPONENT + 2;
    localparam logic [c_EXP_W-1:0] c_EXP_INF = c_EXP_W'((1 << EXPONENT) - 1);
    localparam logic [c_EXP_W-1:0] c_EXP_TOP = c_EXP_W'(IN_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_PACK = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_sign;
    logic [IN_WIDTH-1:0]  r_mag;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_FP_W-1:0]    r_fp;
    logic                 r_inf;

    logic [IN_WIDTH-1:0]  w_abs;
    logic                 w_normed;
    logic [c_EXP_W-1:0]   w_exp_raw;
    logic [c_EXP_W-1:0]   w_exp;
    logic [MANTISSA-1:0]  w_man_raw;
    logic [MANTISSA-1:0]  w_man;
    logic [c_FP_W-1:0]    w_fp;
    logic                 w_inf;

    // The most negative input negates to itself, which read unsigned is 2^(IN_WIDTH-1)
    assign w_abs    = bus.in_data[IN_WIDTH-1] ? (~bus.in_data + 1'b1) : bus.in_data;
    assign w_normed = (r_mag == '0) || r_mag[IN_WIDTH-1];

    assign w_exp_raw = c_EXP_TOP - c_EXP_W'(r_cnt);
    assign w_man_raw = r_mag[IN_WIDTH-2 -: MANTISSA];

`ifdef FP_ENC_ROUND_EN
    localparam int c_MR_W = MANTISSA + 1;
    logic              w_guard;
    logic              w_sticky;
    logic [c_MR_W-1:0] w_man_rnd;

    assign w_guard   = r_mag[IN_WIDTH-2-MANTISSA];
    assign w_sticky  = |(r_mag << (MANTISSA + 2));
    assign w_man_rnd = {1'b0, w_man_raw} + c_MR_W'(w_guard && (w_sticky || w_man_raw[0]));
    // A mantissa carry leaves M at zero and bumps the exponent
    assign w_man     = w_man_rnd[MANTISSA-1:0];
    assign w_exp     = w_exp_raw + c_EXP_W'(w_man_rnd[MANTISSA]);
`else
    assign w_man     = w_man_raw;
    assign w_exp     = w_exp_raw;
`endif

    always_comb begin
        w_fp  = '0;
        w_inf = 1'b0;
        if (r_mag == '0) begin
            w_fp  = '0;
        end else if (w_exp >= c_EXP_INF) begin
            w_fp  = {r_sign, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};
            w_inf = 1'b1;
        end else begin
            w_fp  = {r_sign, w_exp[EXPONENT-1:0], w_man};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) w_state_next = S_NORM;
            end
            S_NORM: begin
                if (w_normed) w_state_next = S_PACK;
            end
            S_PACK: begin
                w_state_next = S_DONE;
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign <= 1'b0;
            r_mag  <= '0;
            r_cnt  <= '0;
            r_fp   <= '0;
            r_inf  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_sign <= bus.in_data[IN_WIDTH-1];
                        r_mag  <= w_abs;
                        r_cnt  <= '0;
                    end
                end
                S_NORM: begin
                    if (!w_normed) begin
                        r_mag <= r_mag << 1;
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_PACK: begin
                    r_fp  <= w_fp;
                    r_inf <= w_inf;
                end
                default: ;
            endcase
        end
    end

    assign bus.out_fp  = r_fp;
    assign bus.out_inf = r_inf;

endmodule
`default_nettype wire
